ysyx_24110006_scoreboard: RTL

YSYX_24110006_SCOREBOARD -- requirements
Module: ysyx_24110006_SCOREBOARD

---
 rtl/ysyx_24110006_pkg.sv | 26 ++
 rtl/ysyx_24110006_scoreboard_cnt.sv | 28 ++
 rtl/ysyx_24110006_scoreboard.sv | 118 +++++++++++
 3 files changed

// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the register scoreboard: RV32 major-opcode classes
// (instruction bits [6:2]) and the default limit on outstanding writers.
package ysyx_24110006_pkg;

   localparam int SB_MAX_INFLIGHT = 4;

   typedef enum logic [4:0] {
      OPC_LOAD   = 5'b00000,
      OPC_FENCE  = 5'b00011,
      OPC_OP_IMM = 5'b00100,
      OPC_AUIPC  = 5'b00101,
      OPC_STORE  = 5'b01000,
      OPC_OP     = 5'b01100,
      OPC_LUI    = 5'b01101,
      OPC_BRANCH = 5'b11000,
      OPC_JALR   = 5'b11001,
      OPC_JAL    = 5'b11011,
      OPC_SYSTEM = 5'b11100
   } opclass_e;

   typedef struct packed {
      logic rs1;
      logic rs2;
   } src_use_t;

endpackage

// File: rtl/ysyx_24110006_scoreboard_cnt.sv
// Two-bit pending-writer counter for one architectural register.
// Clear wins; a simultaneous increment and decrement cancel out.
module ysyx_24110006_SB_CNT (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       i_inc,
   input  logic       i_dec,
   input  logic       i_clr,
   output logic [1:0] o_cnt
);

   logic [1:0] r_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= 2'd0;
      end else if (i_clr) begin
         r_cnt <= 2'd0;
      end else if (i_inc && !i_dec && r_cnt != 2'd3) begin
         r_cnt <= r_cnt + 2'd1;
      end else if (i_dec && !i_inc && r_cnt != 2'd0) begin
         r_cnt <= r_cnt - 2'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_24110006_scoreboard.sv
// Register scoreboard: tracks outstanding writers per register, stalls issue
// on pending sources and limits the total number of writers in flight.
module ysyx_24110006_scoreboard
   import ysyx_24110006_pkg::*;
#(
   parameter int NR_REG       = 16,
   parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_issue_valid,
   output logic              o_issue_ready,
   input  logic [6:0]        i_op,
   input  logic [4:0]        i_rs1,
   input  logic [4:0]        i_rs2,
   input  logic [4:0]        i_rd,
   input  logic              i_wen,
   input  logic              i_wb_valid,
   input  logic [4:0]        i_wb_rd,
   input  logic              i_flush,
   output logic              o_stall,
   output logic [2:0]        o_inflight,
   output logic [NR_REG-1:0] o_busy
);

   localparam int IW = $clog2(NR_REG);

   logic [IW-1:0]     w_rs1Idx;
   logic [IW-1:0]     w_rs2Idx;
   logic [IW-1:0]     w_rdIdx;
   logic [IW-1:0]     w_wbIdx;
   logic [1:0]        w_cnt [NR_REG];
   logic [NR_REG-1:1] w_inc;
   logic [NR_REG-1:1] w_dec;
   src_use_t          w_use;
   logic              w_wrBlock;
   logic              w_fire;
   logic              w_incFire;
   logic              w_wbReq;
   logic              w_sameRd;
   logic              w_decFire;
   logic [2:0]        r_inflight;
   logic              w_unused_bits;

   assign w_rs1Idx = i_rs1[IW-1:0];
   assign w_rs2Idx = i_rs2[IW-1:0];
   assign w_rdIdx  = i_rd[IW-1:0];
   assign w_wbIdx  = i_wb_rd[IW-1:0];
   assign w_unused_bits = ^{i_op[1:0], i_rs1, i_rs2, i_rd, i_wb_rd};

   always_comb begin
      w_use = '0;
      case (i_op[6:2])
         OPC_JALR, OPC_OP_IMM, OPC_LOAD, OPC_SYSTEM: begin
            w_use.rs1 = 1'b1;
         end
         OPC_BRANCH, OPC_STORE, OPC_OP: begin
            w_use.rs1 = 1'b1;
            w_use.rs2 = 1'b1;
         end
         default: begin
            w_use = '0;
         end
      endcase
   end

   // Hazard checks use the counters as they stand before the edge, so a
   // retire in the same cycle never releases a stall early.
   always_comb begin
      o_stall = i_issue_valid &&
                ((w_use.rs1 && w_rs1Idx != '0 && w_cnt[w_rs1Idx] != 2'd0) ||
                 (w_use.rs2 && w_rs2Idx != '0 && w_cnt[w_rs2Idx] != 2'd0));
      w_wrBlock = i_wen && w_rdIdx != '0 &&
                  (w_cnt[w_rdIdx] == 2'd3 || r_inflight == 3'(MAX_INFLIGHT));
   end

   assign o_issue_ready = reset_n && !o_stall && !w_wrBlock && !i_flush;
   assign w_fire        = i_issue_valid && o_issue_ready;
   assign w_incFire     = w_fire && i_wen && w_rdIdx != '0;
   assign w_wbReq       = i_wb_valid && w_wbIdx != '0;
   assign w_sameRd      = w_incFire && w_wbReq && w_rdIdx == w_wbIdx;
   assign w_decFire     = w_wbReq && (w_cnt[w_wbIdx] != 2'd0 || w_sameRd);

   assign w_cnt[0]  = 2'd0;
   assign o_busy[0] = 1'b0;

   for (genvar r = 1; r < NR_REG; r++) begin : g_cnt
      assign w_inc[r] = w_incFire && w_rdIdx == IW'(r);
      assign w_dec[r] = w_wbReq && w_wbIdx == IW'(r);

      ysyx_24110006_SB_CNT u_cnt (
         .clock   (clock),
         .reset_n (reset_n),
         .i_inc   (w_inc[r]),
         .i_dec   (w_dec[r]),
         .i_clr   (i_flush),
         .o_cnt   (w_cnt[r])
      );

      assign o_busy[r] = (w_cnt[r] != 2'd0);
   end

   // Mirrors the sum of the counters: an issue and a retire cancel out.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_inflight <= 3'd0;
      end else if (i_flush) begin
         r_inflight <= 3'd0;
      end else if (w_incFire && !w_decFire) begin
         r_inflight <= r_inflight + 3'd1;
      end else if (w_decFire && !w_incFire) begin
         r_inflight <= r_inflight - 3'd1;
      end
   end

   assign o_inflight = r_inflight;

endmodule
